// File: rtl/psu_pkg.sv
// psu_pkg: shared types and constants for pattern_scan_unit.
//   - psu_state_e : 3-bit FSM state encoding
//   - DEF_*       : default string length and fixed memory addresses
//   - WIN_W/CNT_W : pattern window width and result counter width
package psu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_PAT = 3'd1,
    S_SCAN     = 3'd2,
    S_WR_B     = 3'd3,
    S_WR_O     = 3'd4,
    S_WR_S     = 3'd5,
    S_DONE     = 3'd6
  } psu_state_e;

  localparam int DEF_STR_BYTES = 32;
  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_RES_ADDR  = 33;
  localparam int WIN_W         = 5;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/pattern_scan_unit_if.sv
// pattern_scan_unit_if: start/ack handshake plus data-memory port.
//   master : the scan unit (drives Ack and the memory address/write side)
//   slave  : the system side (drives Start, returns same-cycle MemRdData)
interface pattern_scan_unit_if #(
  parameter int AW = 8
);
  logic          Start;
  logic          Ack;
  logic [AW-1:0] MemAddr;
  logic [7:0]    MemRdData;
  logic          MemWrEn;
  logic [7:0]    MemWrData;

  modport master (
    input  Start, MemRdData,
    output Ack, MemAddr, MemWrEn, MemWrData
  );

  modport slave (
    output Start, MemRdData,
    input  Ack, MemAddr, MemWrEn, MemWrData
  );
endinterface

// File: rtl/psu_byte_matcher.sv
// psu_byte_matcher: combinational window matcher for one message byte.
//   pat       : 5-bit pattern
//   prev      : low nibble of the previous byte (crossing windows)
//   byte_i    : current byte
//   first     : current byte is byte 0, so there are no crossing windows
//   in_cnt    : matches among the 4 windows fully inside byte_i (0..4)
//   cross_cnt : in_cnt plus matches among the 4 windows straddling
//               prev/byte_i (0..8) -- the per-byte increment of the total
//   hit       : at least one in-byte match
module psu_byte_matcher
  import psu_pkg::*;
(
  input  logic [WIN_W-1:0] pat,
  input  logic [3:0]       prev,
  input  logic [7:0]       byte_i,
  input  logic             first,
  output logic [2:0]       in_cnt,
  output logic [3:0]       cross_cnt,
  output logic             hit
);

  logic [11:0] win;
  logic [2:0]  in_c;
  logic [2:0]  x_c;

  assign win = {prev, byte_i};

  always_comb begin
    in_c = '0;
    x_c  = '0;
    for (int i = 0; i < 4; i++) begin
      // In-byte windows [7:3]..[4:0]; straddling windows [11:7]..[8:4].
      if (byte_i[7-i -: WIN_W] == pat) in_c = in_c + 3'd1;
      if (!first && (win[11-i -: WIN_W] == pat)) x_c = x_c + 3'd1;
    end
  end

  assign in_cnt    = in_c;
  assign cross_cnt = {1'b0, in_c} + {1'b0, x_c};
  assign hit       = (in_c != 3'd0);

endmodule

// File: rtl/pattern_scan_unit.sv
// pattern_scan_unit: counts 5-bit pattern occurrences in a message held in
// data memory and writes three counts back to fixed result addresses.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : pattern_scan_unit_if.master (Start/Ack, memory port)
// Optional macro PSU_DEBUG_COUNTS_EN adds DbgCtb/DbgCto/DbgCts/DbgState,
// live views of the counter and state registers.
// All outputs are registered: next-cycle address is chosen on the edge that
// enters a state, so the combinational memory returns data in that state.
module pattern_scan_unit
  import psu_pkg::*;
#(
  parameter int STR_BYTES = DEF_STR_BYTES,
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int RES_ADDR  = DEF_RES_ADDR,
  parameter int AW        = 8
) (
  input  logic Clk,
  input  logic Reset,
  pattern_scan_unit_if.master bus
`ifdef PSU_DEBUG_COUNTS_EN
  ,
  output logic [7:0] DbgCtb,
  output logic [7:0] DbgCto,
  output logic [7:0] DbgCts,
  output logic [2:0] DbgState
`endif
);

  localparam int IW = (STR_BYTES > 1) ? $clog2(STR_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(STR_BYTES - 1);

  psu_state_e       state_q, state_d;
  logic [WIN_W-1:0] pat_q, pat_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic             ack_q, ack_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic [2:0] in_cnt;
  logic [3:0] cross_cnt;
  logic       hit;

  psu_byte_matcher u_match (
    .pat       (pat_q),
    .prev      (prev_q),
    .byte_i    (bus.MemRdData),
    .first     (idx_q == '0),
    .in_cnt    (in_cnt),
    .cross_cnt (cross_cnt),
    .hit       (hit)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    ctb_d     = ctb_q;
    cto_d     = cto_q;
    cts_d     = cts_q;
    ack_d     = 1'b0;
    addr_d    = '0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_LOAD_PAT;
          addr_d  = AW'(PAT_ADDR);
        end
      end
      S_LOAD_PAT: begin
        pat_d   = bus.MemRdData[7:3];
        ctb_d   = '0;
        cto_d   = '0;
        cts_d   = '0;
        idx_d   = '0;
        prev_d  = '0;
        state_d = S_SCAN;
        addr_d  = '0;
      end
      S_SCAN: begin
        ctb_d  = ctb_q + CNT_W'(in_cnt);
        cto_d  = cto_q + CNT_W'(hit);
        cts_d  = cts_q + CNT_W'(cross_cnt);
        prev_d = bus.MemRdData[3:0];
        if (idx_q == LAST_IDX) begin
          // First result write is presented in WR_B, so it takes the
          // count that already includes the final byte.
          state_d   = S_WR_B;
          addr_d    = AW'(RES_ADDR);
          wr_en_d   = 1'b1;
          wr_data_d = ctb_d;
        end else begin
          idx_d  = idx_q + IW'(1);
          addr_d = AW'(idx_q) + AW'(1);
        end
      end
      S_WR_B: begin
        state_d   = S_WR_O;
        addr_d    = AW'(RES_ADDR + 1);
        wr_en_d   = 1'b1;
        wr_data_d = cto_q;
      end
      S_WR_O: begin
        state_d   = S_WR_S;
        addr_d    = AW'(RES_ADDR + 2);
        wr_en_d   = 1'b1;
        wr_data_d = cts_q;
      end
      S_WR_S: begin
        state_d = S_DONE;
        ack_d   = 1'b1;
      end
      S_DONE: begin
        ack_d = 1'b1;
        if (bus.Start) begin
          ack_d   = 1'b0;
          state_d = S_LOAD_PAT;
          addr_d  = AW'(PAT_ADDR);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      prev_q    <= '0;
      ctb_q     <= '0;
      cto_q     <= '0;
      cts_q     <= '0;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      ctb_q     <= ctb_d;
      cto_q     <= cto_d;
      cts_q     <= cts_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.Ack       = ack_q;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWrEn   = wr_en_q;
  assign bus.MemWrData = wr_data_q;

`ifdef PSU_DEBUG_COUNTS_EN
  assign DbgCtb   = ctb_q;
  assign DbgCto   = cto_q;
  assign DbgCts   = cts_q;
  assign DbgState = state_q;
`endif

endmodule

// File: doc/pattern_scan_unit.md
Name: pattern_scan_unit

Overview:
- Hardware accelerator for the program-3 pattern count. Sits between the top-level start/ack handshake and data memory.
- On Start, reads the 5-bit pattern and the 32-byte message from data memory, then computes three counts. It writes the counts back to fixed result addresses and raises Ack.
- Replaces the software loop. Results land at the same memory locations the program-3 bench checks.

Parameters:
- STR_BYTES, 32, message length in bytes (string at addresses 0..STR_BYTES-1)
- PAT_ADDR, 32, address of pattern byte; pattern = byte[7:3]
- RES_ADDR, 33, base of results: +0 in-byte count, +1 byte-hit count, +2 crossing count
- AW, 8, memory address width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request to begin a scan
- Ack  out  1  high when results are written; held until next Start or Reset
- MemAddr  out  AW  data-memory address
- MemRdData  in  8  data-memory read data, combinational (same-cycle) read
- MemWrEn  out  1  data-memory write enable
- MemWrData  out  8  data-memory write data

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state=IDLE; Ack=0, MemWrEn=0, MemAddr=0, MemWrData=0.
  - All counters and the prev-nibble register cleared.
- States: IDLE -> LOAD_PAT -> SCAN -> WR_B -> WR_O -> WR_S -> DONE.
- IDLE: Start=1 moves to LOAD_PAT. Otherwise stay.
- LOAD_PAT (1 cycle):
  - MemAddr=PAT_ADDR; latch pat=MemRdData[7:3].
  - Clear counters; idx=0.
- SCAN (STR_BYTES cycles, one byte per cycle):
  - MemAddr=idx. Byte idx 0 is the most significant byte of the string.
  - In-byte windows: bits [7:3],[6:2],[5:1],[4:0]. Add the number equal to pat (0..4) to ctb. If any match, cto+=1.
  - Crossing windows (idx>0 only): {prev[3:0],byte} slices [11:7],[10:6],[9:5],[8:4]. Add matches to cts.
  - cts also adds the in-byte matches. Total windows = 4+8*(STR_BYTES-1)=252.
  - prev<=byte[3:0]. After idx=STR_BYTES-1, go to WR_B.
- WR_B / WR_O / WR_S (1 cycle each):
  - MemWrEn=1; MemAddr=RES_ADDR+0/+1/+2.
  - MemWrData=ctb/cto/cts respectively.
- DONE:
  - Ack=1, registered, first asserted on the cycle after WR_S. MemWrEn=0.
  - Start=1 clears Ack the next cycle and enters LOAD_PAT.
- Latency: Start cycle +1 (LOAD_PAT) +STR_BYTES +3 writes; Ack high 37 cycles after Start sampled.
- Width rules:
  - Counters are 8-bit unsigned: ctb ≤128, cto ≤32, cts ≤252. No saturation needed.
  - Additions use zero-extended 3-bit per-byte sums.
- Start while in LOAD_PAT..WR_S is ignored.
- Reset mid-scan or mid-write:
  - Abort next edge; no further writes.
  - Partially written results are left as-is; Ack=0.
- MemWrEn is asserted only in WR_* states. MemAddr is don't-care in IDLE/DONE but driven to 0.

Optional Feature:
- Macro PSU_DEBUG_COUNTS_EN.
- Defined: adds outputs DbgCtb[7:0], DbgCto[7:0], DbgCts[7:0], DbgState[2:0]. These show the live counter/state registers, reset to 0.
- Undefined: ports absent; functional behaviour identical.

Decomposition:
- Package psu_pkg holds:
  - the state enum (3-bit);
  - default address constants (PAT_ADDR, RES_ADDR, STR_BYTES);
  - the window count width.
- Sub-module psu_byte_matcher, combinational:
  - Inputs: pat[4:0], prev[3:0], byte[7:0], first flag.
  - Outputs: in_cnt[2:0], cross_cnt[3:0], hit.
  - Top level holds only the FSM, counters and memory interface.

Test Plan:
- All 32 bytes 0x00, Core[32]=0x00 -> Core[33]=128, Core[34]=32, Core[35]=252; Ack high 37 cycles after Start.
- All bytes 0x55, Core[32]=0xA8 (pat 10101) -> 64, 32, 126.
- All bytes 0xFF, pat 00000 -> 0, 0, 0; verify exactly three writes, at addresses 33..35.
- Byte-crossing case: byte5=0x03, byte6=0xE0, others 0, pat 11111 (0xF8) -> 0, 0, 1.
- Reset mid-scan: Start, Reset at cycle 10 -> Ack=0, MemWrEn never asserted; then Start with the case above -> correct results.
- Start pulsed during SCAN is ignored (same results/latency). Start in DONE drops Ack the next cycle and reruns to identical results.
